// File: rtl/store_queue_pkg.sv
// Shared store-queue types: entry record, store-width encodings and the
// wrapping ROB-tag age comparison used by the ROB, LSU and store queue.
package store_queue_pkg;

  localparam int SQ_DATA_W = 32;
  localparam int SQ_ROB_W  = 4;
  localparam int SQ_LANES  = SQ_DATA_W / 8;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;

  typedef struct packed {
    logic                 valid;
    logic                 committed;
    logic [SQ_ROB_W-1:0]  rob_tag;
    logic [SQ_DATA_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_LANES-1:0]  strb;
  } sq_entry_t;

  // a is younger than b when a sits in the half-window ahead of b
  function automatic logic is_younger(input logic [SQ_ROB_W-1:0] a,
                                      input logic [SQ_ROB_W-1:0] b);
    logic [SQ_ROB_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[SQ_ROB_W-1];
  endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// One byte lane of store-to-load forwarding: picks the youngest hitting
// entry by walking the ring from head so later program order wins.
module sq_fwd_select #(
  parameter int SQ_DEPTH = 8,
  parameter int PTR_W    = $clog2(SQ_DEPTH)
) (
  input  logic [PTR_W-1:0]              head,
  input  logic [SQ_DEPTH-1:0]           hit,
  input  logic [SQ_DEPTH-1:0][7:0]      lane_bytes,
  output logic                          hit_any,
  output logic [7:0]                    sel_byte
);

  always_comb begin
    logic [PTR_W-1:0] slot;
    hit_any  = 1'b0;
    sel_byte = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (hit[slot]) begin
        hit_any  = 1'b1;
        sel_byte = lane_bytes[slot];
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Store queue: in-order ring of pending stores with commit marking, ordered
// drain to memory, branch-flush recovery and per-lane load forwarding.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DATA_WIDTH = SQ_DATA_W,
  parameter int ROB_WIDTH  = SQ_ROB_W,
  parameter int SQ_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [ROB_WIDTH-1:0]          alloc_rob_tag,
  input  logic [DATA_WIDTH-1:0]         alloc_addr,
  input  logic [DATA_WIDTH-1:0]         alloc_data,
  input  logic [2:0]                    alloc_funct3,
  input  logic                          commit_valid,
  input  logic [ROB_WIDTH-1:0]          commit_tag,
  input  logic                          branch_mispredict,
  input  logic [ROB_WIDTH-1:0]          branch_rob_tag,
  input  logic [DATA_WIDTH-1:0]         ld_addr,
  input  logic [ROB_WIDTH-1:0]          ld_rob_tag,
  output logic [DATA_WIDTH-1:0]         ld_fwd_data,
  output logic [DATA_WIDTH/8-1:0]       ld_fwd_mask,
  output logic                          mem_wr_valid,
  input  logic                          mem_wr_ready,
  output logic [DATA_WIDTH-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]       mem_wr_strb,
  output logic [$clog2(SQ_DEPTH):0]     o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sq_entry_t             mem [SQ_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  full;
  logic                  alloc_fire;
  logic                  pop;
  logic [SQ_DEPTH-1:0]   kill;
  logic [SQ_DEPTH-1:0]   commit_hit;
  logic [CNT_W-1:0]      surv_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      base_cnt;
  sq_entry_t             new_entry;
  logic [DATA_WIDTH-1:0] al_data;
  logic [LANES-1:0]      al_strb;
  logic [SQ_DEPTH-1:0]   fwd_base;
  logic                  unused_ld;

  assign full        = (count == CNT_W'(SQ_DEPTH));
  assign alloc_ready = !full;
  assign o_count     = count;
  assign o_full      = full;
  assign o_empty     = (count == '0);

  // Allocations younger than a same-cycle mispredict are on the wrong path
  assign alloc_fire = alloc_valid && alloc_ready &&
                      !(branch_mispredict && is_younger(alloc_rob_tag, branch_rob_tag));

  assign mem_wr_valid = mem[head].valid && mem[head].committed;
  assign mem_wr_addr  = {mem[head].addr[DATA_WIDTH-1:2], 2'b00};
  assign mem_wr_data  = mem[head].data;
  assign mem_wr_strb  = mem[head].strb;
  assign pop          = mem_wr_valid && mem_wr_ready;

  always_comb begin
    al_data = alloc_data;
    al_strb = '1;
    case (alloc_funct3)
      F3_SB: begin
        al_data = DATA_WIDTH'(alloc_data[7:0]) << {alloc_addr[1:0], 3'b000};
        al_strb = LANES'(1) << alloc_addr[1:0];
      end
      F3_SH: begin
        al_data = DATA_WIDTH'(alloc_data[15:0]) << {alloc_addr[1], 4'b0000};
        al_strb = LANES'(3) << {alloc_addr[1], 1'b0};
      end
      default: begin
        al_data = alloc_data;
        al_strb = '1;
      end
    endcase
  end

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.committed = 1'b0;
    new_entry.rob_tag   = alloc_rob_tag;
    new_entry.addr      = alloc_addr;
    new_entry.data      = al_data;
    new_entry.strb      = al_strb;
  end

  // Killed entries form a suffix in program order, so the new tail sits
  // right after the youngest survivor walking forward from head.
  always_comb begin
    logic [PTR_W-1:0] slot;
    kill     = '0;
    surv_cnt = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (branch_mispredict && mem[slot].valid && !mem[slot].committed &&
            is_younger(mem[slot].rob_tag, branch_rob_tag))
          kill[slot] = 1'b1;
        else
          surv_cnt = CNT_W'(k + 1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++)
      commit_hit[i] = commit_valid && mem[i].valid && !kill[i] &&
                      (mem[i].rob_tag == commit_tag);
  end

  assign wr_ptr   = branch_mispredict ? head + surv_cnt[PTR_W-1:0] : tail;
  assign base_cnt = branch_mispredict ? surv_cnt : count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SQ_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (kill[i]) begin
          mem[i].valid     <= 1'b0;
          mem[i].committed <= 1'b0;
        end else if (commit_hit[i]) begin
          mem[i].committed <= 1'b1;
        end
      end
      if (pop) begin
        mem[head].valid     <= 1'b0;
        mem[head].committed <= 1'b0;
      end
      if (alloc_fire)
        mem[wr_ptr] <= new_entry;
      head  <= head + PTR_W'(pop);
      tail  <= wr_ptr + PTR_W'(alloc_fire);
      count <= base_cnt + CNT_W'(alloc_fire) - CNT_W'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++)
      fwd_base[i] = mem[i].valid && is_younger(ld_rob_tag, mem[i].rob_tag) &&
                    (mem[i].addr[DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2]);
  end

  assign unused_ld = ^ld_addr[1:0];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SQ_DEPTH-1:0]      lane_hit;
    logic [SQ_DEPTH-1:0][7:0] lane_bytes;

    always_comb begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        lane_hit[i]   = fwd_base[i] && mem[i].strb[l];
        lane_bytes[i] = mem[i].data[8*l +: 8];
      end
    end

    sq_fwd_select #(
      .SQ_DEPTH (SQ_DEPTH),
      .PTR_W    (PTR_W)
    ) u_fwd_select (
      .head       (head),
      .hit        (lane_hit),
      .lane_bytes (lane_bytes),
      .hit_any    (ld_fwd_mask[l]),
      .sel_byte   (ld_fwd_data[8*l +: 8])
    );
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DATA_WIDTH, 32, data/address width in bits; byte lanes = DATA_WIDTH/8.
REQ-002 Parameter ROB_WIDTH, 4, ROB tag width.
REQ-003 Parameter SQ_DEPTH, 8, entry count; power of two, >= 2.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid  in  1, alloc_ready  out  1  store allocation handshake.
REQ-007 alloc_rob_tag  in  ROB_WIDTH, alloc_addr  in  DATA_WIDTH, alloc_data  in  DATA_WIDTH, alloc_funct3  in  3  store payload (000 SB, 001 SH, other SW).
REQ-008 commit_valid  in  1, commit_tag  in  ROB_WIDTH  ROB retire of one store per cycle.
REQ-009 branch_mispredict  in  1, branch_rob_tag  in  ROB_WIDTH  flush of all entries younger than the tag.
REQ-010 ld_addr  in  DATA_WIDTH, ld_rob_tag  in  ROB_WIDTH  forwarding query for a load.
REQ-011 ld_fwd_data  out  DATA_WIDTH, ld_fwd_mask  out  DATA_WIDTH/8  forwarded bytes and lane-valid mask.
REQ-012 mem_wr_valid  out  1, mem_wr_ready  in  1  drain handshake to data memory.
REQ-013 mem_wr_addr  out  DATA_WIDTH (word-aligned), mem_wr_data  out  DATA_WIDTH (lane-aligned), mem_wr_strb  out  DATA_WIDTH/8.
REQ-014 o_count  out  $clog2(SQ_DEPTH)+1, o_full  out  1, o_empty  out  1  occupancy status.

Function
REQ-015 Circular FIFO, head/tail pointers wrap modulo SQ_DEPTH; entries held in program order.
REQ-016 alloc_ready = !o_full; write at tail, tail+1, when alloc_valid && alloc_ready.
REQ-017 Allocation aligns the payload: data shifted into its byte lanes; strobe = 1 lane (SB), 2 lanes at addr[1] (SH), all lanes (SW).
REQ-018 Age rule: A is younger than B iff (A-B) mod 2^ROB_WIDTH is nonzero and < 2^(ROB_WIDTH-1).
REQ-019 Commit: the valid entry whose tag equals commit_tag is marked committed next cycle; a non-matching commit is ignored.
REQ-020 Drain: mem_wr_valid = head entry valid && committed; pop head on mem_wr_valid && mem_wr_ready.
REQ-021 mem_wr_addr/data/strb SHALL hold stable while mem_wr_valid && !mem_wr_ready.
REQ-022 Flush: on branch_mispredict, every uncommitted entry younger than branch_rob_tag is invalidated, and tail is set to the slot after the youngest survivor (or to head if none survive).
REQ-023 A same-cycle allocation younger than branch_rob_tag SHALL be dropped; an older one SHALL be accepted.
REQ-024 A same-cycle commit of an entry being flushed SHALL be ignored; drain-pop and flush in one cycle both take effect.
REQ-025 Simultaneous alloc and pop when full: alloc_ready stays low (full evaluated pre-pop).
REQ-026 Forwarding is combinational. For each lane, select the youngest valid entry older than ld_rob_tag with matching addr[DATA_WIDTH-1:2] and that lane's strobe set; set the mask bit and drive its byte. Lanes with no match drive mask 0 and data 0.
REQ-027 o_count = valid entries; o_full = (o_count == SQ_DEPTH); o_empty = (o_count == 0); updated on the same edge as pointers.

Reset
REQ-028 Reset asserted: head = tail = 0, all valid/committed bits 0, o_count = 0, o_empty = 1, o_full = 0, alloc_ready = 1, mem_wr_valid = 0, ld_fwd_mask = 0.
REQ-029 Reset mid-drain discards all entries, including committed ones; no memory write is issued after reset assertion.

Structure
REQ-030 A shared package holds the sq_entry_t typedef (valid, committed, rob_tag, addr, data, strb), the funct3 encodings and an is_younger age function reused by the ROB and the LSU.
REQ-031 One sub-module, sq_fwd_select: per-lane youngest-older-match priority selection, instantiated once per byte lane.

Verification
REQ-032 Fill: 8 SW allocations, tags 0-7 -> o_full=1, alloc_ready=0, o_count=8; a 9th alloc_valid is not accepted.
REQ-033 Drain backpressure: commit tag 0, hold mem_wr_ready=0 for 3 cycles -> mem_wr_valid=1 with addr/data/strb stable; ready=1 -> pop, o_count decrements by 1.
REQ-034 Forwarding: SW 0x100=0xAABBCCDD tag 2, SB 0x101=0x11 tag 3, load tag 5 addr 0x100 -> ld_fwd_data=0xAABB11DD, mask=1111; load tag 3 -> 0xAABBCCDD.
REQ-035 Flush: tags 4,5,6,7 allocated, tag 4 committed, mispredict tag 5 -> entries 6,7 removed, o_count=2, tail=head+2; a same-cycle alloc of tag 8 is dropped.
REQ-036 Wrap: 20 alloc/commit/drain cycles with SQ_DEPTH=4 and tag wrap 15->0 -> memory writes issued in program order, no tag-age misordering.
